// File: rtl/axi_burst_shim.sv
// Bridges a simple grant-based read/write request interface onto AXI4.
// Writes are buffered so the requester is released on grant; reads and responses pass through.

package riscv;
  localparam int unsigned XLEN = 64;
endpackage

package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = riscv::XLEN;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;
endpackage

module axi_burst_shim #(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned AxiNumWords    = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = ariane_axi::req_t,
  parameter type         axi_rsp_t      = ariane_axi::resp_t,
  // A single-word configuration still needs a 1-bit length field.
  localparam int unsigned BlenW = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1,
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     rd_req_i,
  output logic                                     rd_gnt_o,
  input  logic [AxiAddrWidth-1:0]                  rd_addr_i,
  input  logic [BlenW-1:0]                         rd_blen_i,
  input  logic [2:0]                               rd_size_i,
  input  logic [AxiIdWidth-1:0]                    rd_id_i,
  input  logic                                     rd_lock_i,
  input  logic                                     rd_rdy_i,
  output logic                                     rd_valid_o,
  output logic                                     rd_last_o,
  output logic [AxiDataWidth-1:0]                  rd_data_o,
  output logic [AxiIdWidth-1:0]                    rd_id_o,
  output logic                                     rd_exokay_o,
  input  logic                                     wr_req_i,
  output logic                                     wr_gnt_o,
  input  logic [AxiAddrWidth-1:0]                  wr_addr_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth-1:0] wr_data_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0] wr_be_i,
  input  logic [BlenW-1:0]                         wr_blen_i,
  input  logic [2:0]                               wr_size_i,
  input  logic [AxiIdWidth-1:0]                    wr_id_i,
  input  logic                                     wr_lock_i,
  input  logic [5:0]                               wr_atop_i,
  input  logic                                     wr_rdy_i,
  output logic                                     wr_valid_o,
  output logic [AxiIdWidth-1:0]                    wr_id_o,
  output logic                                     wr_exokay_o,
  output axi_req_t                                 axi_req_o,
  input  axi_rsp_t                                 axi_resp_i,
  input  logic [riscv::XLEN-1:0]                   patid_i,
  output logic [OutW-1:0]                          rd_outstanding_o,
  output logic [OutW-1:0]                          wr_outstanding_o
);

  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);
  localparam logic [1:0]      RespExOkay = 2'b01;

  typedef enum logic {IDLE, BUSY} wr_state_e;

  wr_state_e r_state, w_state_nxt;

  logic [AxiAddrWidth-1:0]                    r_addr;
  logic [AxiNumWords-1:0][AxiDataWidth-1:0]   r_data;
  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0] r_be;
  logic [BlenW-1:0]                           r_blen;
  logic [2:0]                                 r_size;
  logic [AxiIdWidth-1:0]                      r_id;
  logic                                       r_lock;
  logic [5:0]                                 r_atop;
  logic                                       r_aw_done, r_w_done;
  logic [BlenW-1:0]                           r_cnt;
  logic [OutW-1:0]                            r_wr_out, r_rd_out;

  logic w_wr_gnt, w_aw_valid, w_w_valid, w_aw_fire, w_w_fire, w_w_last;
  logic w_b_fire, w_ar_valid, w_ar_fire, w_r_last_fire;
  logic w_unused;

  assign w_aw_valid    = (r_state == BUSY) & ~r_aw_done;
  assign w_w_valid     = (r_state == BUSY) & ~r_w_done;
  assign w_aw_fire     = w_aw_valid & axi_resp_i.aw_ready;
  assign w_w_fire      = w_w_valid & axi_resp_i.w_ready;
  assign w_w_last      = (r_cnt == r_blen);
  assign w_b_fire      = axi_resp_i.b_valid & wr_rdy_i;
  assign w_ar_valid    = rd_req_i & (r_rd_out < MaxOut);
  assign w_ar_fire     = w_ar_valid & axi_resp_i.ar_ready;
  assign w_r_last_fire = axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.last;
  assign w_unused      = ^{axi_resp_i.b.user, axi_resp_i.r.user};

  always_comb begin
    w_state_nxt = r_state;
    w_wr_gnt    = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by reset so no grant is visible while the block is held in reset.
        w_wr_gnt = rst_ni & wr_req_i & (r_wr_out < MaxOut);
        if (w_wr_gnt) w_state_nxt = BUSY;
      end
      BUSY: begin
        if ((r_aw_done | w_aw_fire) & (r_w_done | (w_w_fire & w_w_last)))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_be      <= '0;
      r_blen    <= '0;
      r_size    <= '0;
      r_id      <= '0;
      r_lock    <= 1'b0;
      r_atop    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_gnt) begin
        r_addr    <= wr_addr_i;
        r_data    <= wr_data_i;
        r_be      <= wr_be_i;
        r_blen    <= wr_blen_i;
        r_size    <= wr_size_i;
        r_id      <= wr_id_i;
        r_lock    <= wr_lock_i;
        r_atop    <= wr_atop_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_cnt     <= '0;
      end else if (r_state == BUSY) begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire) begin
          r_cnt <= r_cnt + BlenW'(1);
          if (w_w_last) r_w_done <= 1'b1;
        end
      end
    end
  end

  // Read count floors at zero: R bursts returned for atomics were never counted on AR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_out <= '0;
      r_rd_out <= '0;
    end else begin
      case ({w_aw_fire, w_b_fire})
        2'b10:   r_wr_out <= r_wr_out + OutW'(1);
        2'b01:   r_wr_out <= r_wr_out - OutW'(1);
        default: r_wr_out <= r_wr_out;
      endcase
      case ({w_ar_fire, w_r_last_fire})
        2'b10:   r_rd_out <= r_rd_out + OutW'(1);
        2'b01:   if (r_rd_out != '0) r_rd_out <= r_rd_out - OutW'(1);
        default: r_rd_out <= r_rd_out;
      endcase
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = r_id;
    axi_req_o.aw.addr  = r_addr;
    axi_req_o.aw.len   = 8'(r_blen);
    axi_req_o.aw.size  = r_size;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw.lock  = r_lock;
    axi_req_o.aw.cache = 4'b0010;
    axi_req_o.aw.atop  = r_atop;
    axi_req_o.aw.user  = patid_i;
    axi_req_o.aw_valid = w_aw_valid;
    axi_req_o.w.data   = r_data[r_cnt];
    axi_req_o.w.strb   = r_be[r_cnt];
    axi_req_o.w.last   = w_w_last;
    axi_req_o.w_valid  = w_w_valid;
    axi_req_o.b_ready  = wr_rdy_i;
    axi_req_o.ar.id    = rd_id_i;
    axi_req_o.ar.addr  = rd_addr_i;
    axi_req_o.ar.len   = 8'(rd_blen_i);
    axi_req_o.ar.size  = rd_size_i;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar.lock  = rd_lock_i;
    axi_req_o.ar.cache = 4'b0010;
    axi_req_o.ar.user  = patid_i;
    axi_req_o.ar_valid = w_ar_valid;
    axi_req_o.r_ready  = rd_rdy_i;
  end

  assign wr_gnt_o         = w_wr_gnt;
  assign wr_valid_o       = axi_resp_i.b_valid;
  assign wr_id_o          = axi_resp_i.b.id;
  assign wr_exokay_o      = (axi_resp_i.b.resp == RespExOkay);
  assign rd_gnt_o         = w_ar_fire;
  assign rd_valid_o       = axi_resp_i.r_valid;
  assign rd_last_o        = axi_resp_i.r.last;
  assign rd_data_o        = axi_resp_i.r.data;
  assign rd_id_o          = axi_resp_i.r.id;
  assign rd_exokay_o      = (axi_resp_i.r.resp == RespExOkay);
  assign wr_outstanding_o = r_wr_out;
  assign rd_outstanding_o = r_rd_out;

endmodule

// File: tb/tb_axi_burst_shim.sv
// Scoreboard bench for axi_burst_shim: directed stimulus pushes expected AXI beats,
// a negedge monitor pops and compares them on every handshake / response.

module tb_axi_burst_shim;
  localparam int NW = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              rd_req, rd_gnt, rd_lock, rd_rdy, rd_valid, rd_last, rd_exokay;
  logic [63:0]       rd_addr, rd_data;
  logic [1:0]        rd_blen;
  logic [2:0]        rd_size;
  logic [3:0]        rd_id, rd_id_o;
  logic              wr_req, wr_gnt, wr_lock, wr_rdy, wr_valid, wr_exokay;
  logic [63:0]       wr_addr;
  logic [NW-1:0][63:0] wr_data;
  logic [NW-1:0][7:0]  wr_be;
  logic [1:0]        wr_blen;
  logic [2:0]        wr_size;
  logic [3:0]        wr_id, wr_id_o;
  logic [5:0]        wr_atop;
  ariane_axi::req_t  axi_req;
  ariane_axi::resp_t axi_resp;
  logic [63:0]       patid = 64'hA5A5_0000_0000_0042;
  logic [1:0]        rd_out, wr_out;

  axi_burst_shim #(.MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
    .rd_size_i(rd_size), .rd_id_i(rd_id), .rd_lock_i(rd_lock), .rd_rdy_i(rd_rdy),
    .rd_valid_o(rd_valid), .rd_last_o(rd_last), .rd_data_o(rd_data), .rd_id_o(rd_id_o),
    .rd_exokay_o(rd_exokay),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_size_i(wr_size), .wr_id_i(wr_id),
    .wr_lock_i(wr_lock), .wr_atop_i(wr_atop), .wr_rdy_i(wr_rdy), .wr_valid_o(wr_valid),
    .wr_id_o(wr_id_o), .wr_exokay_o(wr_exokay),
    .axi_req_o(axi_req), .axi_resp_i(axi_resp), .patid_i(patid),
    .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out)
  );

  int npass = 0, ntotal = 0;
  int waited, w3;
  logic [255:0] q_aw[$], q_w[$], q_ar[$], q_r[$], q_b[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_evt(input string name, input string what);
    ntotal++;
    $display("FAIL %s: got %s", name, what);
  endtask

  function automatic logic [63:0] wd(input int seed, input int k);
    return {32'(seed), 32'(k) ^ 32'h0BAD_0000};
  endfunction

  function automatic logic [7:0] wb(input int k);
    return 8'hff >> k;
  endfunction

  function automatic logic [255:0] aw_exp(input logic [63:0] a, input logic [1:0] bl,
                                          input logic [3:0] id, input logic [5:0] atop);
    return {a, 8'(bl), id, atop, 2'b01, 4'b0010, patid, 3'd3, 1'b0, 3'b0, 4'b0, 4'b0};
  endfunction

  function automatic logic [255:0] ar_exp(input logic [63:0] a, input logic [1:0] bl,
                                          input logic [3:0] id);
    return {a, 8'(bl), id, 2'b01, 4'b0010, patid, 3'd3, 1'b0, 3'b0, 4'b0, 4'b0};
  endfunction

  function automatic logic [255:0] w_exp(input int seed, input int k, input logic last);
    return {wd(seed, k), wb(k), last};
  endfunction

  // Monitor: every handshake the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi_req.aw_valid && axi_resp.aw_ready) begin
        if (q_aw.size() == 0) fail_evt("aw_unexpected", "an AW handshake, expected none");
        else chk("aw", {axi_req.aw.addr, axi_req.aw.len, axi_req.aw.id, axi_req.aw.atop,
                        axi_req.aw.burst, axi_req.aw.cache, axi_req.aw.user, axi_req.aw.size,
                        axi_req.aw.lock, axi_req.aw.prot, axi_req.aw.qos, axi_req.aw.region},
                 q_aw.pop_front());
      end
      if (axi_req.w_valid && axi_resp.w_ready) begin
        if (q_w.size() == 0) fail_evt("w_unexpected", "a W handshake, expected none");
        else chk("w", {axi_req.w.data, axi_req.w.strb, axi_req.w.last}, q_w.pop_front());
      end
      if (axi_req.ar_valid && axi_resp.ar_ready) begin
        if (q_ar.size() == 0) fail_evt("ar_unexpected", "an AR handshake, expected none");
        else chk("ar", {axi_req.ar.addr, axi_req.ar.len, axi_req.ar.id, axi_req.ar.burst,
                        axi_req.ar.cache, axi_req.ar.user, axi_req.ar.size, axi_req.ar.lock,
                        axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region}, q_ar.pop_front());
      end
      if (wr_valid) begin
        if (q_b.size() == 0) fail_evt("b_unexpected", "a B response, expected none");
        else chk("b", {wr_id_o, wr_exokay, axi_req.b_ready}, q_b.pop_front());
      end
      if (rd_valid) begin
        if (q_r.size() == 0) fail_evt("r_unexpected", "an R response, expected none");
        else chk("r", {rd_data, rd_id_o, rd_last, rd_exokay, axi_req.r_ready}, q_r.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [63:0] a, input logic [1:0] bl, input logic [3:0] id,
                          input logic [5:0] atop, input int seed, input bit push_exp,
                          output int n);
    wr_addr = a; wr_blen = bl; wr_id = id; wr_atop = atop; wr_size = 3'd3; wr_lock = 1'b0;
    for (int k = 0; k < NW; k++) begin
      wr_data[k] = wd(seed, k);
      wr_be[k]   = wb(k);
    end
    if (push_exp) begin
      q_aw.push_back(aw_exp(a, bl, id, atop));
      for (int k = 0; k <= int'(bl); k++) q_w.push_back(w_exp(seed, k, k == int'(bl)));
    end
    wr_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wr_gnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!wr_gnt) fail_evt("wr_gnt_timeout", "no grant, expected grant within 40 cycles");
    @(posedge clk); #1;
    wr_req = 1'b0;
    wr_data = '1;
  endtask

  task automatic probe_gnt(input logic exp, input string name);
    wr_req = 1'b1;
    @(negedge clk);
    chk(name, wr_gnt, exp);
    #1 wr_req = 1'b0;
  endtask

  task automatic b_pulse(input logic [3:0] id, input logic [1:0] resp);
    axi_resp.b_valid = 1'b1; axi_resp.b.id = id; axi_resp.b.resp = resp;
    q_b.push_back({id, resp == 2'b01, 1'b1});
    tick();
    axi_resp.b_valid = 1'b0;
  endtask

  task automatic r_pulse(input logic [3:0] id, input logic [63:0] d, input logic last,
                         input logic [1:0] resp);
    axi_resp.r_valid = 1'b1; axi_resp.r.id = id; axi_resp.r.data = d;
    axi_resp.r.last = last; axi_resp.r.resp = resp;
    q_r.push_back({d, id, last, resp == 2'b01, 1'b1});
    tick();
    axi_resp.r_valid = 1'b0;
  endtask

  task automatic ar_issue(input logic [63:0] a, input logic [1:0] bl, input logic [3:0] id);
    rd_req = 1'b1; rd_addr = a; rd_blen = bl; rd_id = id; rd_size = 3'd3; rd_lock = 1'b0;
    q_ar.push_back(ar_exp(a, bl, id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_req = 0; rd_addr = 0; rd_blen = 0; rd_size = 0; rd_id = 0; rd_lock = 0; rd_rdy = 1;
    wr_req = 0; wr_addr = 0; wr_data = '0; wr_be = '0; wr_blen = 0; wr_size = 0; wr_id = 0;
    wr_lock = 0; wr_atop = 0; wr_rdy = 1; axi_resp = '0;

    // Reset state, with a pending write request that must not be granted.
    repeat (3) tick();
    wr_req = 1'b1;
    @(negedge clk);
    chk("rst_gnt_valids", {wr_gnt, axi_req.aw_valid, axi_req.w_valid}, 3'b000);
    chk("rst_counts", {wr_out, rd_out}, 4'h0);
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    axi_resp.aw_ready = 1; axi_resp.w_ready = 1; axi_resp.ar_ready = 1;
    tick();

    // Single-beat write: grant cycle 0, AW and W(last) together in cycle 1.
    issue_wr(64'h1000, 2'd0, 4'h3, 6'h00, 1, 1'b1, waited);
    chk("t1_gnt_cycle0", waited, 0);
    @(negedge clk);
    chk("t1_aw_w_same_cycle", {axi_req.aw_valid, axi_req.w_valid}, 2'b11);
    tick();
    chk("t1_wr_out_1", wr_out, 2'd1);
    chk("t1_idle_valids", {axi_req.aw_valid, axi_req.w_valid}, 2'b00);
    probe_gnt(1'b1, "t1_idle_gnt");
    tick();
    b_pulse(4'h3, 2'b01);
    chk("t1_wr_out_0", wr_out, 2'd0);

    // 4-beat write with AW stalled: W completes first, AW follows.
    axi_resp.aw_ready = 0;
    issue_wr(64'h2000, 2'd3, 4'h5, 6'h00, 2, 1'b1, waited);
    chk("t2_gnt_cycle0", waited, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("t2_w_done_aw_pending", {axi_req.aw_valid, axi_req.w_valid}, 2'b10);
    tick();
    tick();
    axi_resp.aw_ready = 1;
    tick();
    chk("t2_idle_after_aw", {axi_req.aw_valid, axi_req.w_valid, wr_out}, {2'b00, 2'd1});
    probe_gnt(1'b1, "t2_idle_gnt");
    tick();
    b_pulse(4'h5, 2'b00);
    chk("t2_wr_out_0", wr_out, 2'd0);

    // Outstanding limit of 2: third write waits for a B handshake.
    issue_wr(64'h3000, 2'd0, 4'h1, 6'h00, 3, 1'b1, waited);
    chk("t3_first_gnt", waited, 0);
    issue_wr(64'h3100, 2'd1, 4'h2, 6'h00, 4, 1'b1, waited);
    chk("t3_no_gnt_in_busy", waited, 1);
    fork
      issue_wr(64'h3200, 2'd2, 4'h6, 6'h21, 5, 1'b1, w3);
      begin
        repeat (3) tick();
        chk("t3_wr_out_2", wr_out, 2'd2);
        b_pulse(4'h1, 2'b01);
      end
    join
    chk("t3_third_gnt_after_b", w3, 4);
    repeat (4) tick();
    b_pulse(4'h2, 2'b01);
    b_pulse(4'h6, 2'b00);
    chk("t3_wr_out_0", wr_out, 2'd0);

    // Read accounting.
    ar_issue(64'h4000, 2'd2, 4'h7);
    @(negedge clk);
    chk("t4_rd_gnt", rd_gnt, 1'b1);
    tick();
    chk("t4_rd_out_1", rd_out, 2'd1);
    ar_issue(64'h4100, 2'd0, 4'h8);
    r_pulse(4'h7, 64'hDEAD_BEEF_0000_0001, 1'b1, 2'b01);
    rd_req = 1'b0;
    chk("t4_ar_and_rlast_same_cycle", rd_out, 2'd1);
    r_pulse(4'h8, 64'hDEAD_BEEF_0000_0002, 1'b1, 2'b00);
    chk("t4_rd_out_drain", rd_out, 2'd0);
    ar_issue(64'h5000, 2'd1, 4'h9);
    tick();
    ar_issue(64'h5100, 2'd3, 4'hA);
    tick();
    q_ar.push_back(ar_exp(64'h5200, 2'd0, 4'hB));
    rd_addr = 64'h5200; rd_blen = 2'd0; rd_id = 4'hB;
    @(negedge clk);
    chk("t4_ar_blocked_at_limit", {rd_gnt, axi_req.ar_valid, rd_out}, {2'b00, 2'd2});
    #1 rd_req = 1'b0;
    void'(q_ar.pop_back());
    tick();
    r_pulse(4'h9, 64'h0123_4567_89AB_CDEF, 1'b0, 2'b00);
    chk("t4_nonlast_r_keeps_count", rd_out, 2'd2);
    r_pulse(4'h9, 64'hFEDC_BA98_7654_3210, 1'b1, 2'b01);
    r_pulse(4'hA, 64'h1111_2222_3333_4444, 1'b1, 2'b00);
    chk("t4_two_rlast_to_0", rd_out, 2'd0);
    r_pulse(4'hC, 64'h5555_6666_7777_8888, 1'b1, 2'b01);
    chk("t4_rd_out_saturates", rd_out, 2'd0);

    // Reset in the middle of a burst.
    ar_issue(64'h6000, 2'd0, 4'hD);
    tick();
    rd_req = 1'b0;
    axi_resp.aw_ready = 0;
    issue_wr(64'h7000, 2'd3, 4'h4, 6'h00, 6, 1'b0, waited);
    q_w.push_back(w_exp(6, 0, 1'b0));
    q_w.push_back(w_exp(6, 1, 1'b0));
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valids", {axi_req.aw_valid, axi_req.w_valid}, 2'b00);
    chk("t5_rst_counts", {wr_out, rd_out}, 4'h0);
    wr_req = 1'b1;
    #1;
    chk("t5_rst_no_gnt", wr_gnt, 1'b0);
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    axi_resp.aw_ready = 1;
    issue_wr(64'h8000, 2'd1, 4'h2, 6'h00, 7, 1'b1, waited);
    chk("t5_idle_after_release", waited, 0);
    repeat (3) tick();
    b_pulse(4'h2, 2'b00);
    chk("t5_wr_out_0", wr_out, 2'd0);

    tick();
    chk("queues_drained", {q_aw.size(), q_w.size(), q_ar.size(), q_r.size(), q_b.size()}, '0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/axi_burst_shim.md
AXI_BURST_SHIM -- requirements
Module: axi_burst_shim

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64: AXI address width.
REQ-002 SHALL have parameter AxiDataWidth, default 64: AXI data width.
REQ-003 SHALL have parameter AxiIdWidth, default 4: AXI ID width, minimum 2.
REQ-004 SHALL have parameter AxiNumWords, default 4: maximum burst beats, minimum 1.
REQ-005 SHALL have parameter MaxOutstanding, default 4: per-direction outstanding transaction limit, minimum 1.
REQ-006 SHALL have parameters axi_req_t and axi_rsp_t, defaults ariane_axi::req_t and ariane_axi::resp_t: AXI bundle types.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have rd_req_i in 1, rd_gnt_o out 1, rd_addr_i in AxiAddrWidth, rd_blen_i in clog2(AxiNumWords) (LEN-1), rd_size_i in 3, rd_id_i in AxiIdWidth, rd_lock_i in 1.
REQ-010 SHALL have rd_rdy_i in 1, rd_valid_o out 1, rd_last_o out 1, rd_data_o out AxiDataWidth, rd_id_o out AxiIdWidth, rd_exokay_o out 1.
REQ-011 SHALL have wr_req_i in 1, wr_gnt_o out 1, wr_addr_i in AxiAddrWidth, wr_data_i in AxiNumWords x AxiDataWidth, wr_be_i in AxiNumWords x AxiDataWidth/8, wr_blen_i, wr_size_i in 3, wr_id_i, wr_lock_i in 1, wr_atop_i in 6.
REQ-012 SHALL have wr_rdy_i in 1, wr_valid_o out 1, wr_id_o out AxiIdWidth, wr_exokay_o out 1.
REQ-013 SHALL have axi_req_o out axi_req_t, axi_resp_i in axi_rsp_t, patid_i in riscv::XLEN (AR/AW user).
REQ-014 SHALL have rd_outstanding_o and wr_outstanding_o, out, clog2(MaxOutstanding+1) bits each: live outstanding counts.

Function
REQ-015 SHALL drive AW/AR with burst INCR, cache MODIFIABLE, prot/region/qos 0, len = blen, user = patid_i, and AW atop from the captured request.
REQ-016 Write FSM SHALL have states IDLE and BUSY.
REQ-017 In IDLE, wr_gnt_o SHALL equal wr_req_i AND wr_outstanding_o < MaxOutstanding; on grant, all wr_* fields SHALL be captured into an internal buffer and the FSM SHALL go to BUSY, so the requester is released in the grant cycle.
REQ-018 In BUSY, aw_valid SHALL be high until the AW handshake (aw_done flag), and w_valid SHALL be high until the last W handshake, independently, with no ordering between AW and W.
REQ-019 W beat counter SHALL start at 0, increment per W handshake, select data/strb[counter], and drive w.last when counter equals captured blen.
REQ-020 BUSY SHALL return to IDLE in the cycle after both aw_done and the last-W handshake, including when they occur in the same cycle; wr_gnt_o SHALL be 0 in BUSY.
REQ-021 wr_outstanding SHALL increment on each AW handshake and decrement on each B handshake; simultaneous events SHALL leave it unchanged.
REQ-022 B channel SHALL pass through: b_ready = wr_rdy_i, wr_valid_o = b_valid, wr_id_o = b.id, wr_exokay_o = (b.resp == EXOKAY).
REQ-023 ar_valid SHALL be rd_req_i AND rd_outstanding_o < MaxOutstanding, and rd_gnt_o SHALL be ar_valid AND ar_ready; AR fields SHALL be combinational from rd_* inputs.
REQ-024 rd_outstanding SHALL increment on AR handshake and decrement on R handshake with r.last; simultaneous events SHALL leave it unchanged; decrement SHALL saturate at 0 (ATOP R responses are untracked).
REQ-025 R channel SHALL pass through: r_ready = rd_rdy_i, data/id/last/valid to rd_*, rd_exokay_o = (r.resp == EXOKAY).
REQ-026 A single-beat write (blen 0) SHALL complete with AW and W accepted in the same cycle and take exactly 2 cycles from grant to IDLE.

Reset
REQ-027 On rst_ni low, FSM SHALL go to IDLE and counters, flags and buffer SHALL clear asynchronously; aw_valid, w_valid and wr_gnt_o SHALL be 0, and outstanding outputs SHALL be 0.
REQ-028 Reset mid-burst SHALL abandon the transaction without completion; the first cycle after reset release SHALL behave as IDLE.

Verification
REQ-029 Single write, blen 0, aw_ready = w_ready = 1 -> wr_gnt_o in cycle 0, AW and W(last) in cycle 1, wr_outstanding 1, then 0 after B.
REQ-030 4-beat write, aw_ready held 0 for 6 cycles, w_ready 1 -> all 4 W beats go first, last on beat 3, AW afterwards, IDLE the next cycle.
REQ-031 MaxOutstanding = 2, three writes with B withheld -> third wr_gnt_o stays 0 until one B handshake, then is granted.
REQ-032 AR and last-R handshake in the same cycle with count 1 -> rd_outstanding stays 1; 2 ARs then 2 R lasts -> 0.
REQ-033 Reset asserted at W beat 2 of 4 -> valids drop immediately, counts 0, and the next write starts at beat 0.
